// File: rtl/mult_div_sequencer.sv
// Multicycle signed MULT/DIV engine: 32 shift-add or restoring-divide steps on
// operand magnitudes, then a sign-fix cycle that writes the HI/LO registers.
module mult_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_r;
  logic               op_r;
  logic               sign_x_r;
  logic               sign_a_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH:0]     mag_b_r;
  logic [2*WIDTH:0]   acc_r;

  logic [WIDTH:0]     mag_a_s;
  logic [WIDTH:0]     mag_b_s;
  logic [WIDTH:0]     upper_s;
  logic [WIDTH-1:0]   lower_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     shifted_s;
  logic [WIDTH+1:0]   diff_s;
  logic [2*WIDTH:0]   step_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;

  // Magnitude is one bit wider than the operand so |0x80000000| is exact.
  function automatic logic [WIDTH:0] abs_mag(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      abs_mag = {1'b0, ~v} + {{WIDTH{1'b0}}, 1'b1};
    end else begin
      abs_mag = {1'b0, v};
    end
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_dbl(input logic [2*WIDTH-1:0] v,
                                                      input logic n);
    if (n) begin
      cond_neg_dbl = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cond_neg_dbl = v;
    end
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    if (n) begin
      cond_neg = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cond_neg = v;
    end
  endfunction

  // One iteration of shift-add (MULT) or restoring division (DIV), plus sign fix-up.
  // acc_r holds {upper, lower}: product high/low during MULT, {remainder, quotient} during DIV.
  always_comb begin
    mag_a_s   = abs_mag(a);
    mag_b_s   = abs_mag(b);
    upper_s   = acc_r[2*WIDTH:WIDTH];
    lower_s   = acc_r[WIDTH-1:0];
    sum_s     = upper_s + (lower_s[0] ? mag_b_r : {(WIDTH+1){1'b0}});
    shifted_s = {upper_s[WIDTH-1:0], lower_s[WIDTH-1]};
    diff_s    = {1'b0, shifted_s} - {1'b0, mag_b_r};
    if (!op_r) begin
      step_s = {1'b0, sum_s, lower_s[WIDTH-1:1]};
    end else if (!diff_s[WIDTH+1]) begin
      step_s = {diff_s[WIDTH:0], lower_s[WIDTH-2:0], 1'b1};
    end else begin
      step_s = {shifted_s, lower_s[WIDTH-2:0], 1'b0};
    end
    prod_s = cond_neg_dbl(acc_r[2*WIDTH-1:0], sign_x_r);
    quo_s  = cond_neg(lower_s, sign_x_r);
    rem_s  = cond_neg(upper_s[WIDTH-1:0], sign_a_r);
  end

  // Control FSM with registered status outputs and HI/LO write-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      op_r     <= 1'b0;
      sign_x_r <= 1'b0;
      sign_a_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      mag_b_r  <= {(WIDTH+1){1'b0}};
      acc_r    <= {(2*WIDTH+1){1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      div0     <= 1'b0;
      hi       <= {WIDTH{1'b0}};
      lo       <= {WIDTH{1'b0}};
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (op && (b == {WIDTH{1'b0}})) begin
              div0 <= 1'b1;
            end else begin
              op_r     <= op;
              sign_x_r <= a[WIDTH-1] ^ b[WIDTH-1];
              sign_a_r <= a[WIDTH-1];
              mag_b_r  <= mag_b_s;
              acc_r    <= {{WIDTH{1'b0}}, mag_a_s};
              cnt_r    <= {CNT_W{1'b0}};
              busy     <= 1'b1;
              state_r  <= RUN;
            end
          end
        end
        RUN: begin
          acc_r <= step_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(WIDTH-1)) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          if (op_r) begin
            hi <= rem_s;
            lo <= quo_s;
          end else begin
            hi <= prod_s[2*WIDTH-1:WIDTH];
            lo <= prod_s[WIDTH-1:0];
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer: stimulus pushes expected HI/LO and
// event cycle; a negedge monitor pops and compares on every done/div0 pulse.
module tb_mult_div_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    bit          is_div0;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks;
  int   errors;
  int   cyc;
  int   busy_run;

  mult_div_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare each done/div0 pulse against the oldest expectation.
  always @(negedge clk) begin
    if (done || div0) begin
      check("done_div0_exclusive", 64'(done & div0), 64'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%0b div0=%0b at cycle %0d with empty scoreboard",
                 done, div0, cyc);
      end else begin
        e = q.pop_front();
        check("pulse_kind_div0", 64'(div0), 64'(e.is_div0));
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("pulse_cycle", 64'(cyc), 64'(e.cyc));
        check("busy_low_at_pulse", 64'(busy), 64'd0);
        if (!e.is_div0) begin
          check("busy_cycles", 64'(busy_run), 64'd33);
        end
      end
    end
    if (busy) busy_run = busy_run + 1;
    else      busy_run = 0;
  end

  // Called just after a negedge; the following posedge samples start.
  task automatic issue(input logic o, input logic [31:0] av, input logic [31:0] bv,
                       input bit push, input bit d0, input logic [31:0] eh,
                       input logic [31:0] el);
    exp_t x;
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    if (push) begin
      x.is_div0 = d0;
      x.hi      = eh;
      x.lo      = el;
      x.cyc     = d0 ? (cyc + 1) : (cyc + 34);
      q.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
    op    = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    busy_run = 0;
    reset    = 1'b0;
    start    = 1'b0;
    op       = 1'b0;
    a        = 32'd0;
    b        = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_div0", 64'(div0), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Signed MULT, then back-to-back start in the done cycle.
    issue(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    wait_done();
    issue(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h4000_0000, 32'h0000_0000);
    wait_done();

    // Signed DIV truncating toward zero, then most-negative / -1 wraps.
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_done();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0000, 32'h8000_0000);
    wait_done();

    // Divide by zero leaves HI/LO untouched.
    issue(1'b0, 32'd5, 32'd5, 1'b1, 1'b0, 32'd0, 32'd25);
    wait_done();
    repeat (2) @(negedge clk);
    issue(1'b1, 32'd9, 32'd0, 1'b1, 1'b1, 32'd0, 32'd25);
    check("div0_no_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("div0_hold_hi", 64'(hi), 64'd0);
    check("div0_hold_lo", 64'(lo), 64'd25);

    // Start while busy is ignored.
    issue(1'b0, 32'd3, 32'd4, 1'b1, 1'b0, 32'd0, 32'd12);
    repeat (4) @(negedge clk);
    issue(1'b1, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_done();
    repeat (40) @(negedge clk);

    // Asynchronous reset aborts an operation in flight.
    issue(1'b0, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd12 - 64'd12);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(1'b0, 32'd2, 32'd2, 1'b1, 1'b0, 32'd0, 32'd4);
    wait_done();
    repeat (5) @(negedge clk);

    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
